breath_ramp: RTL and testbench



---
 rtl/breath_ramp.sv | 185 ++++++++++++++++++
 tb/tb_breath_ramp.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/breath_ramp.sv
`timescale 1ns/1ps
// breath_ramp
//   Brightness envelope generator for the pulsing-LED PWM stage. The
//   envelope is a triangle: rise, hold high, fall, hold low, repeat. Level
//   changes happen only on the prescaled step tick. The PWM compare value
//   (duty) is loaded only on pwm_sync, so the PWM never sees a change in the
//   middle of a period.
//
//   Optional feature: define BREATH_RAMP_GAMMA_EN to apply a squared
//   (gamma-like) curve, f(l) = (l*l + 2^WIDTH-1) >> WIDTH. This adds one
//   pipeline register. Without the macro, duty follows level linearly.
//
// Ports
//   clk         in   1      system clock
//   rst         in   1      synchronous, active-high reset
//   en          in   1      run envelope (level-sensitive)
//   pwm_sync    in   1      1-cycle pulse from the PWM at period start
//   duty        out  WIDTH  registered duty value for the PWM compare
//   duty_valid  out  1      1-cycle pulse, the cycle after duty is loaded
//   phase       out  3      FSM state: IDLE=0 RISE=1 HOLD_HI=2 FALL=3 HOLD_LO=4
//
// Handshake: pwm_sync is a strobe with no back-pressure. Each pulse samples
// the level at that clock edge. The sampled value (after f) then appears on
// duty, and duty_valid pulses high for exactly one cycle on the following
// cycle. When there is no pwm_sync, duty holds its value.
module breath_ramp #(
  parameter int WIDTH      = 8,
  parameter int STEP_DIV   = 23437,
  parameter int HOLD_STEPS = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             pwm_sync,
  output logic [WIDTH-1:0] duty,
  output logic             duty_valid,
  output logic [2:0]       phase
);

  localparam int PW = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
  localparam int HW = (HOLD_STEPS > 1) ? $clog2(HOLD_STEPS + 1) : 1;
  localparam logic [WIDTH-1:0] LVL_MAX = '1;
  localparam logic [PW-1:0]    PRE_TOP = PW'(STEP_DIV - 1);
  localparam logic [HW-1:0]    HOLD_TOP = HW'(HOLD_STEPS - 1);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RISE    = 3'd1,
    HOLD_HI = 3'd2,
    FALL    = 3'd3,
    HOLD_LO = 3'd4
  } state_t;

  state_t            state_q, state_d;
  logic [WIDTH-1:0]  level_q, level_d;
  logic [PW-1:0]     pre_q, pre_d;
  logic [HW-1:0]     hold_q, hold_d;
  logic              tick;

  // The prescaler is parked at 0 in IDLE, so the first step after leaving
  // IDLE comes a full STEP_DIV cycles later.
  assign tick = (state_q != IDLE) && (pre_q == PRE_TOP);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      level_q <= '0;
      pre_q   <= '0;
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      level_q <= level_d;
      pre_q   <= pre_d;
      hold_q  <= hold_d;
    end
  end

  always_comb begin
    state_d = state_q;
    level_d = level_q;
    hold_d  = hold_q;
    pre_d   = (state_q == IDLE || tick) ? '0 : pre_q + 1'b1;

    case (state_q)
      IDLE: begin
        if (en) begin
          state_d = RISE;
          level_d = '0;
        end
      end
      RISE: begin
        if (tick) begin
          // A drop of en turns the ramp around without spending a step.
          if (!en) begin
            state_d = FALL;
          end else begin
            if (level_q != LVL_MAX) level_d = level_q + 1'b1;
            if (level_q >= LVL_MAX - 1'b1) begin
              state_d = HOLD_HI;
              hold_d  = '0;
            end
          end
        end
      end
      HOLD_HI: begin
        if (tick) begin
          if (!en || hold_q == HOLD_TOP) state_d = FALL;
          else                           hold_d  = hold_q + 1'b1;
        end
      end
      FALL: begin
        if (tick) begin
          if (level_q != '0) level_d = level_q - 1'b1;
          // At the bottom, go to IDLE if the run was cancelled. If en is
          // still (or again) high, take the normal low hold.
          if (level_q <= {{(WIDTH-1){1'b0}}, 1'b1}) begin
            state_d = en ? HOLD_LO : IDLE;
            hold_d  = '0;
          end
        end
      end
      HOLD_LO: begin
        if (tick) begin
          if (!en)                    state_d = IDLE;
          else if (hold_q == HOLD_TOP) state_d = RISE;
          else                        hold_d  = hold_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign phase = state_q;

  // Duty path. load_q marks the cycle in which duty has just been loaded.
  // duty_valid is that marker delayed by one cycle.
  logic [WIDTH-1:0] duty_q;
  logic             load_q;
  logic             valid_q;

`ifdef BREATH_RAMP_GAMMA_EN
  logic [2*WIDTH-1:0] sq;
  logic [WIDTH-1:0]   curve_q;
  logic               sync_q;

  // (l*l + max) >> WIDTH: the bias maps max to max and 0 to 0, and the
  // result always fits in 2*WIDTH bits.
  always_comb begin
    sq = {{WIDTH{1'b0}}, level_q} * {{WIDTH{1'b0}}, level_q}
       + {{WIDTH{1'b0}}, LVL_MAX};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      curve_q <= '0;
      sync_q  <= 1'b0;
      duty_q  <= '0;
      load_q  <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      sync_q  <= pwm_sync;
      if (pwm_sync) curve_q <= sq[2*WIDTH-1:WIDTH];
      if (sync_q)   duty_q  <= curve_q;
      load_q  <= sync_q;
      valid_q <= load_q;
    end
  end
`else
  always_ff @(posedge clk) begin
    if (rst) begin
      duty_q  <= '0;
      load_q  <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      if (pwm_sync) duty_q <= level_q;
      load_q  <= pwm_sync;
      valid_q <= load_q;
    end
  end
`endif

  assign duty       = duty_q;
  assign duty_valid = valid_q;

endmodule

// File: tb/tb_breath_ramp.sv
`timescale 1ns/1ps
module tb_breath_ramp;

  localparam int WIDTH      = 4;
  localparam int STEP_DIV   = 3;
  localparam int HOLD_STEPS = 2;
  localparam int LMAX       = (1 << WIDTH) - 1;
`ifdef BREATH_RAMP_GAMMA_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  // ---------------- clock / reset ----------------
  logic             clk = 1'b0;
  logic             rst;
  logic             en;
  logic             pwm_sync;
  logic [WIDTH-1:0] duty;
  logic             duty_valid;
  logic [2:0]       phase;

  always #5 clk = ~clk;

  breath_ramp #(.WIDTH(WIDTH), .STEP_DIV(STEP_DIV), .HOLD_STEPS(HOLD_STEPS)) dut (
    .clk(clk), .rst(rst), .en(en), .pwm_sync(pwm_sync),
    .duty(duty), .duty_valid(duty_valid), .phase(phase)
  );

  // ---------------- reference envelope model ----------------
  int m_state, m_level, m_hold, m_cnt;
  always @(posedge clk) begin
    bit tk;
    if (rst) begin
      m_state <= 0; m_level <= 0; m_hold <= 0; m_cnt <= 0;
    end else begin
      tk = (m_state != 0) && (m_cnt == STEP_DIV - 1);
      m_cnt <= (m_state == 0 || tk) ? 0 : m_cnt + 1;
      case (m_state)
        0: if (en) begin m_state <= 1; m_level <= 0; end
        1: if (tk) begin
             if (!en) m_state <= 3;
             else if (m_level + 1 >= LMAX) begin m_level <= LMAX; m_state <= 2; m_hold <= 0; end
             else m_level <= m_level + 1;
           end
        2: if (tk) begin
             if (!en || m_hold + 1 >= HOLD_STEPS) m_state <= 3;
             else m_hold <= m_hold + 1;
           end
        3: if (tk) begin
             if (m_level <= 1) begin m_level <= 0; m_state <= en ? 4 : 0; m_hold <= 0; end
             else m_level <= m_level - 1;
           end
        4: if (tk) begin
             if (!en) m_state <= 0;
             else if (m_hold + 1 >= HOLD_STEPS) m_state <= 1;
             else m_hold <= m_hold + 1;
           end
        default: m_state <= 0;
      endcase
    end
  end

  function automatic int f_duty(int l);
`ifdef BREATH_RAMP_GAMMA_EN
    return (l * l + LMAX) >> WIDTH;
`else
    return l;
`endif
  endfunction

  // ---------------- scoreboard ----------------
  logic [WIDTH-1:0] exp_q[$];
  int               due_q[$];
  logic [WIDTH-1:0] last_exp;
  logic [WIDTH-1:0] last_valid;
  int               checks   = 0;
  int               failures = 0;
  int               cyc_n    = 0;
  bit               sync_auto;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%0d exp=%0d t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic push_exp();
    exp_q.push_back(WIDTH'(f_duty(m_level)));
    due_q.push_back(cyc_n + 1 + LAT);
  endtask

  // One clock: advance, check outputs against the model and the scoreboard,
  // then drive the next pwm_sync.
  task automatic cyc();
    @(posedge clk);
    cyc_n++;
    #1;
    check("phase", phase, m_state);
    if (due_q.size() > 0 && cyc_n == due_q[0] - 1) begin
      check("duty_load", duty, exp_q[0]);
      last_exp = exp_q[0];
    end else begin
      check("duty_hold", duty, last_exp);
    end
    if (duty_valid) begin
      if (due_q.size() == 0) check("valid_spurious", duty_valid, 0);
      else begin
        check("valid_time", cyc_n, due_q[0]);
        check("valid_duty", duty, exp_q[0]);
        last_valid = duty;
        void'(exp_q.pop_front());
        void'(due_q.pop_front());
      end
    end else if (due_q.size() > 0 && cyc_n >= due_q[0]) begin
      check("valid_missing", duty_valid, 1);
      void'(exp_q.pop_front());
      void'(due_q.pop_front());
    end
    if (sync_auto && !rst && (cyc_n % 4 == 0)) begin
      pwm_sync = 1'b1;
      push_exp();
    end else begin
      pwm_sync = 1'b0;
    end
  endtask

  task automatic pulse_sync();
    pwm_sync = 1'b1;
    push_exp();
    cyc();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    pwm_sync = 1'b0;
    exp_q.delete();
    due_q.delete();
    last_exp = '0;
    cyc();
    rst = 1'b0;
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int n;
    rst = 1'b1; en = 1'b0; pwm_sync = 1'b0; sync_auto = 1'b0;
    last_exp = '0; last_valid = '0;
    do_reset();
    do_reset();
    check("init_duty", duty, 0);
    check("init_phase", phase, 0);
    check("init_valid", duty_valid, 0);

    // Reset in the middle of a rise.
    sync_auto = 1'b1;
    en = 1'b1;
    for (int i = 0; i < 200 && !(m_state == 1 && m_level == 9); i++) cyc();
    check("reach_l9_timeout", (m_state == 1 && m_level == 9), 1);
    en = 1'b0;
    do_reset();
    check("rst_duty", duty, 0);
    check("rst_phase", phase, 0);
    check("rst_valid", duty_valid, 0);
    repeat (12) cyc();
    check("idle_stays", phase, 0);

    // Full envelope period from IDLE.
    en = 1'b1;
    cyc();
    check("rise_start", phase, 1);
    repeat (44) cyc();
    check("rise_44", phase, 1);
    cyc();
    check("hold_hi_45", phase, 2);
    repeat (5) cyc();
    check("hold_hi_50", phase, 2);
    cyc();
    check("fall_51", phase, 3);
    repeat (50) cyc();
    check("hold_lo_101", phase, 4);
    cyc();
    check("rise_102", phase, 1);

    // No pwm_sync for 20 clocks: duty must hold.
    sync_auto = 1'b0;
    repeat (4) cyc();
    repeat (20) cyc();
    check("hold_20_duty", duty, last_exp);
    pulse_sync();
    repeat (LAT + 2) cyc();
    check("single_valid_drained", exp_q.size(), 0);
    check("single_valid_low", duty_valid, 0);

    // pwm_sync coincident with the step tick at level 7.
    for (int i = 0; i < 250 && !(m_state == 1 && m_level == 7 && m_cnt == STEP_DIV - 1); i++) cyc();
    check("reach_l7_timeout", (m_state == 1 && m_level == 7 && m_cnt == STEP_DIV - 1), 1);
    pulse_sync();
    repeat (LAT + 2) cyc();
    check("coincident_duty", last_valid, f_duty(7));

    // en dropped at level 10 during RISE: turn around, fall, go IDLE.
    sync_auto = 1'b1;
    for (int i = 0; i < 250 && !(m_state == 1 && m_level == 10); i++) cyc();
    check("reach_l10_timeout", (m_state == 1 && m_level == 10), 1);
    en = 1'b0;
    n = 0;
    while (n < 6 && phase != 3) begin cyc(); n++; end
    check("fall_entry_clks", n, STEP_DIV);
    n = 0;
    while (n < 60 && phase == 3) begin cyc(); n++; end
    check("fall_clks", n, 10 * STEP_DIV);
    check("after_fall_idle", phase, 0);

    // en dropped in HOLD_HI, reasserted mid-fall: normal HOLD_LO follows.
    en = 1'b1;
    for (int i = 0; i < 100 && phase != 2; i++) cyc();
    check("reach_hold_hi", phase, 2);
    en = 1'b0;
    for (int i = 0; i < 6 && phase != 3; i++) cyc();
    check("hold_hi_abort", phase, 3);
    repeat (3 * STEP_DIV) cyc();
    en = 1'b1;
    for (int i = 0; i < 60 && phase == 3; i++) cyc();
    check("refall_hold_lo", phase, 4);
    en = 1'b0;
    for (int i = 0; i < 6 && phase == 4; i++) cyc();
    check("hold_lo_abort_idle", phase, 0);

    // Drain and report.
    sync_auto = 1'b0;
    repeat (6) cyc();
    check("queue_empty", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
